// File: rtl/cpu_io_pkg.sv
// rtl/cpu_io_pkg.sv - shared types and sizes for the CPU serial I/O path
//
// Purpose: state encoding, datapath widths and the bit-count normaliser used
// by serial_word_sender.
// Ports: none (package).

package cpu_io_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int WORD_W = 32;
  localparam int SEL_W  = 5;
  localparam int LEN_W  = 6;

  // A count of 0 or anything above the word width means "whole word".
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    if ((len == '0) || (len > LEN_W'(WORD_W))) begin
      return LEN_W'(WORD_W);
    end
    return len;
  endfunction

endpackage

// File: rtl/one_bit_mux_32.sv
// rtl/one_bit_mux_32.sv - 32:1 single-bit selector
//
// Purpose: picks one bit out of a 32-bit word.
// Ports:
//   data  in  32  source word
//   sel   in  5   bit index
//   y     out 1   data[sel]

module one_bit_mux_32 (
  input  logic [31:0] data,
  input  logic [4:0]  sel,
  output logic        y
);

  assign y = data[sel];

endmodule

// File: rtl/serial_word_sender.sv
// rtl/serial_word_sender.sv - bit-serial transmit stage for memory-mapped I/O words
//
// Purpose: accepts a 32-bit word and a bit count on a valid/ready load port,
// then emits the bits one per accepted beat on a valid/ready serial port.
// Ports:
//   clock       in  1   system clock, rising edge
//   reset       in  1   synchronous active-high reset
//   abort       in  1   synchronous flush of the word in flight
//   load_valid  in  1   producer has a word
//   load_ready  out 1   word accepted this cycle when load_valid is high
//   load_data   in  32  word to send
//   load_len    in  6   bit count 1..32 (0 or >32 means 32)
//   bit_valid   out 1   bit_out is valid
//   bit_ready   in  1   consumer takes bit_out this cycle
//   bit_out     out 1   current bit, held_word[sel]
//   bit_last    out 1   current bit is the final one of the word
//   sel_out     out 5   current bit index
//   busy        out 1   a word is being sent

module serial_word_sender
  import cpu_io_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              abort,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WORD_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_len,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              bit_out,
  output logic              bit_last,
  output logic [SEL_W-1:0]  sel_out,
  output logic              busy
);

  state_t             state, state_n;
  logic [WORD_W-1:0]  held_word, held_word_n;
  logic [SEL_W-1:0]   sel, sel_n;
  logic [LEN_W-1:0]   remaining, remaining_n;
  logic [LEN_W-1:0]   len_eff;
  logic               beat;
  logic               load_fire;

  // Everything except load_ready comes straight from registers.
  assign bit_valid = (state == SEND);
  assign bit_last  = bit_valid & (remaining == LEN_W'(1));
  assign busy      = bit_valid;
  assign sel_out   = sel;

  assign beat      = bit_valid & bit_ready;
  // Accepting on the final beat lets the next word start with no idle cycle.
  assign load_ready = ~abort & ((state == IDLE) | (beat & bit_last));
  assign load_fire  = load_valid & load_ready;
  assign len_eff    = eff_len(load_len);

  one_bit_mux_32 u_bit_mux (
    .data (held_word),
    .sel  (sel),
    .y    (bit_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      held_word <= '0;
      sel       <= '0;
      remaining <= '0;
    end else begin
      state     <= state_n;
      held_word <= held_word_n;
      sel       <= sel_n;
      remaining <= remaining_n;
    end
  end

  always_comb begin
    state_n     = state;
    held_word_n = held_word;
    sel_n       = sel;
    remaining_n = remaining;

    if (abort) begin
      // held_word is deliberately kept; only the in-flight progress is dropped.
      state_n     = IDLE;
      sel_n       = '0;
      remaining_n = '0;
    end else if (load_fire) begin
      state_n     = SEND;
      held_word_n = load_data;
      remaining_n = len_eff;
      sel_n       = MSB_FIRST ? SEL_W'(len_eff - LEN_W'(1)) : '0;
    end else if (beat) begin
      if (bit_last) begin
        state_n = IDLE;
      end else begin
        remaining_n = remaining - LEN_W'(1);
        sel_n       = MSB_FIRST ? (sel - SEL_W'(1)) : (sel + SEL_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_serial_word_sender.sv
// tb/tb_serial_word_sender.sv - directed self-checking bench for serial_word_sender

module tb_serial_word_sender;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  // LSB-first instance
  logic        a_abort = 1'b0, a_load_valid = 1'b0, a_load_ready;
  logic [31:0] a_load_data = '0;
  logic [5:0]  a_load_len = '0;
  logic        a_bit_valid, a_bit_ready = 1'b0, a_bit_out, a_bit_last, a_busy;
  logic [4:0]  a_sel_out;

  // MSB-first instance
  logic        b_abort = 1'b0, b_load_valid = 1'b0, b_load_ready;
  logic [31:0] b_load_data = '0;
  logic [5:0]  b_load_len = '0;
  logic        b_bit_valid, b_bit_ready = 1'b0, b_bit_out, b_bit_last, b_busy;
  logic [4:0]  b_sel_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  serial_word_sender #(.MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .abort(a_abort),
    .load_valid(a_load_valid), .load_ready(a_load_ready),
    .load_data(a_load_data), .load_len(a_load_len),
    .bit_valid(a_bit_valid), .bit_ready(a_bit_ready), .bit_out(a_bit_out),
    .bit_last(a_bit_last), .sel_out(a_sel_out), .busy(a_busy)
  );

  serial_word_sender #(.MSB_FIRST(1'b1)) dut_msb (
    .clock(clock), .reset(reset), .abort(b_abort),
    .load_valid(b_load_valid), .load_ready(b_load_ready),
    .load_data(b_load_data), .load_len(b_load_len),
    .bit_valid(b_bit_valid), .bit_ready(b_bit_ready), .bit_out(b_bit_out),
    .bit_last(b_bit_last), .sel_out(b_sel_out), .busy(b_busy)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_lsb_reset_outputs(input string tag);
    chk({tag, "_bit_valid"}, 32'(a_bit_valid), 32'd0);
    chk({tag, "_bit_out"}, 32'(a_bit_out), 32'd0);
    chk({tag, "_bit_last"}, 32'(a_bit_last), 32'd0);
    chk({tag, "_busy"}, 32'(a_busy), 32'd0);
    chk({tag, "_sel_out"}, 32'(a_sel_out), 32'd0);
    chk({tag, "_load_ready"}, 32'(a_load_ready), 32'd1);
  endtask

  // Loads a word on the LSB-first instance and counts beats with bit_ready high.
  task automatic run_len_lsb(input logic [31:0] d, input logic [5:0] l,
                             output int beats, output int last_at);
    a_load_valid = 1'b1; a_load_data = d; a_load_len = l; a_bit_ready = 1'b1;
    tick;
    a_load_valid = 1'b0;
    beats = 0;
    last_at = -1;
    while (a_bit_valid && beats < 40) begin
      if (a_bit_last) last_at = beats;
      beats++;
      tick;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] word;
    int beats, last_at, cycles;
    int msb_sel [4] = '{3, 2, 1, 0};
    int msb_bit [4] = '{1, 0, 1, 1};
    int ready_pat [10] = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1};

    // Reset state
    tick; tick;
    reset = 1'b0;
    check_lsb_reset_outputs("rst");
    chk("rst_msb_load_ready", 32'(b_load_ready), 32'd1);
    chk("rst_msb_bit_valid", 32'(b_bit_valid), 32'd0);

    // Full 32-bit LSB-first word
    word = 32'hA5A5_0001;
    a_load_valid = 1'b1; a_load_data = word; a_load_len = 6'd32; a_bit_ready = 1'b1;
    #1;
    chk("t1_load_ready", 32'(a_load_ready), 32'd1);
    tick;
    a_load_valid = 1'b0;
    chk("t1_first_bit", 32'(a_bit_out), 32'd1);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("t1_valid_%0d", i), 32'(a_bit_valid), 32'd1);
      chk($sformatf("t1_bit_%0d", i), 32'(a_bit_out), 32'(word[i]));
      chk($sformatf("t1_sel_%0d", i), 32'(a_sel_out), 32'(i));
      chk($sformatf("t1_last_%0d", i), 32'(a_bit_last), (i == 31) ? 32'd1 : 32'd0);
      tick;
    end
    chk("t1_busy_done", 32'(a_busy), 32'd0);
    chk("t1_valid_done", 32'(a_bit_valid), 32'd0);
    chk("t1_ready_done", 32'(a_load_ready), 32'd1);

    // MSB-first 4-bit word 0xB
    b_load_valid = 1'b1; b_load_data = 32'h0000_000B; b_load_len = 6'd4; b_bit_ready = 1'b1;
    tick;
    b_load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_valid_%0d", i), 32'(b_bit_valid), 32'd1);
      chk($sformatf("t2_sel_%0d", i), 32'(b_sel_out), 32'(msb_sel[i]));
      chk($sformatf("t2_bit_%0d", i), 32'(b_bit_out), 32'(msb_bit[i]));
      chk($sformatf("t2_last_%0d", i), 32'(b_bit_last), (i == 3) ? 32'd1 : 32'd0);
      tick;
    end
    chk("t2_idle", 32'(b_busy), 32'd0);

    // Length normalisation and single-bit word
    run_len_lsb(32'hFFFF_0000, 6'd0, beats, last_at);
    chk("t3_len0_beats", 32'(beats), 32'd32);
    chk("t3_len0_last", 32'(last_at), 32'd31);
    run_len_lsb(32'h1234_5678, 6'd40, beats, last_at);
    chk("t3_len40_beats", 32'(beats), 32'd32);
    chk("t3_len40_last", 32'(last_at), 32'd31);
    a_load_valid = 1'b1; a_load_data = 32'h0000_0001; a_load_len = 6'd1;
    tick;
    a_load_valid = 1'b0;
    chk("t3_len1_valid", 32'(a_bit_valid), 32'd1);
    chk("t3_len1_bit", 32'(a_bit_out), 32'd1);
    chk("t3_len1_last", 32'(a_bit_last), 32'd1);
    chk("t3_len1_sel", 32'(a_sel_out), 32'd0);
    tick;
    chk("t3_len1_done", 32'(a_bit_valid), 32'd0);

    // Stalls: bit_ready 1,0,0,1,... on word 0x6 len 4 (bits 0,1,1,0)
    word = 32'h0000_0006;
    a_load_valid = 1'b1; a_load_data = word; a_load_len = 6'd4;
    tick;
    a_load_valid = 1'b0;
    beats = 0;
    cycles = 0;
    for (int c = 0; c < 10; c++) begin
      if (a_bit_valid) begin
        a_bit_ready = ready_pat[c][0];
        cycles++;
        chk($sformatf("t4_sel_c%0d", c), 32'(a_sel_out), 32'(beats));
        chk($sformatf("t4_bit_c%0d", c), 32'(a_bit_out), 32'(word[beats]));
        if (a_bit_ready) beats++;
      end
      tick;
    end
    a_bit_ready = 1'b1;
    chk("t4_beats", 32'(beats), 32'd4);
    chk("t4_send_cycles", 32'(cycles), 32'd6);

    // Back-to-back: word1 0x5 len 3, word2 0x2 len 2
    a_load_valid = 1'b1; a_load_data = 32'h0000_0005; a_load_len = 6'd3;
    tick;
    chk("t5_b0_bit", 32'(a_bit_out), 32'd1);
    a_load_data = 32'h0000_0002; a_load_len = 6'd2;
    #1;
    chk("t5_b0_ready_blocked", 32'(a_load_ready), 32'd0);
    tick;
    chk("t5_b1_bit", 32'(a_bit_out), 32'd0);
    chk("t5_b1_ready_blocked", 32'(a_load_ready), 32'd0);
    tick;
    chk("t5_b2_last", 32'(a_bit_last), 32'd1);
    chk("t5_b2_bit", 32'(a_bit_out), 32'd1);
    chk("t5_b2_ready", 32'(a_load_ready), 32'd1);
    tick;
    a_load_valid = 1'b0;
    chk("t5_w2_valid", 32'(a_bit_valid), 32'd1);
    chk("t5_w2_sel0", 32'(a_sel_out), 32'd0);
    chk("t5_w2_bit0", 32'(a_bit_out), 32'd0);
    chk("t5_w2_last0", 32'(a_bit_last), 32'd0);
    tick;
    chk("t5_w2_bit1", 32'(a_bit_out), 32'd1);
    chk("t5_w2_last1", 32'(a_bit_last), 32'd1);
    tick;
    chk("t5_idle", 32'(a_busy), 32'd0);

    // Abort at beat 5 of a 16-bit word with a competing load
    a_load_valid = 1'b1; a_load_data = 32'h0000_FFFF; a_load_len = 6'd16;
    tick;
    a_load_valid = 1'b0;
    repeat (5) tick;
    chk("t6_sel_before", 32'(a_sel_out), 32'd5);
    a_abort = 1'b1; a_load_valid = 1'b1; a_load_data = 32'h0000_1234; a_load_len = 6'd8;
    #1;
    chk("t6_ready_forced0", 32'(a_load_ready), 32'd0);
    tick;
    a_abort = 1'b0; a_load_valid = 1'b0;
    chk("t6_valid", 32'(a_bit_valid), 32'd0);
    chk("t6_busy", 32'(a_busy), 32'd0);
    chk("t6_sel", 32'(a_sel_out), 32'd0);
    chk("t6_last", 32'(a_bit_last), 32'd0);
    chk("t6_held_kept", 32'(a_bit_out), 32'd1);
    tick;
    chk("t6_no_load", 32'(a_bit_valid), 32'd0);

    // Reset mid-word
    a_load_valid = 1'b1; a_load_data = 32'hFFFF_FFFF; a_load_len = 6'd32;
    tick;
    a_load_valid = 1'b0;
    tick; tick;
    chk("t7_busy_before", 32'(a_busy), 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_lsb_reset_outputs("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_sender.md
Name: serial_word_sender

Overview:
- Bit-serial transmit stage. Accepts a 32-bit word plus a bit count over a valid/ready load handshake, then emits the bits one per accepted beat on a valid/ready serial output.
- Owns the 5-bit bit-index counter. That counter drives the select input of the team's existing 32:1 one-bit mux, one_bit_mux_32, which picks the current bit out of the held word.
- Sits between the CPU's memory-mapped I/O write path and the serial peripheral driver (feeder motor/LED line).

Parameters:
- MSB_FIRST, 0: 0 sends bit 0 first, ascending; 1 sends bit len-1 first, descending.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- abort  input  1  synchronous flush of the word in flight.
- load_valid  input  1  producer has a word.
- load_ready  output  1  block accepts the word this cycle.
- load_data  input  32  word to send.
- load_len  input  6  bit count 1..32; values 0 or >32 are treated as 32.
- bit_valid  output  1  bit_out is valid.
- bit_ready  input  1  consumer takes bit_out this cycle.
- bit_out  output  1  current bit, equal to held_word[sel].
- bit_last  output  1  current bit is the final bit of the word.
- sel_out  output  5  current bit index (debug/observability).
- busy  output  1  high when state is SEND.

Behaviour:
- Clocking: single clock. Reset is synchronous and active-high; port names are clock and reset.
- Reset values: state IDLE, held_word 0, sel 0, remaining 0. Outputs after reset: bit_valid 0, bit_out 0, bit_last 0, busy 0, sel_out 0, load_ready 1.
- Register set: state {IDLE, SEND}, held_word[31:0], sel[4:0], remaining[5:0].
- All outputs except load_ready are functions of registers only. bit_out comes from one_bit_mux_32(held_word, sel).
- load_ready = !abort & (state==IDLE | (bit_valid & bit_ready & bit_last)). This permits back-to-back words with no bubble.
- Load (load_valid & load_ready):
  - held_word <= load_data.
  - remaining <= effective length L.
  - sel <= 0 if MSB_FIRST=0, else L-1.
  - state <= SEND.
- SEND:
  - bit_valid=1, bit_last=(remaining==1).
  - Beat accepted when bit_valid & bit_ready.
  - Beat accepted, not last: remaining <= remaining-1; sel <= sel+1 (MSB_FIRST=0) or sel-1 (MSB_FIRST=1).
  - Beat accepted, last, with no same-cycle load: state <= IDLE.
  - Beat accepted, last, with a same-cycle load: the load rule applies and state stays SEND.
- Stall: while bit_ready=0 in SEND, all registers hold and bit_out is stable.
- Latency: the first bit is valid the cycle after the load handshake. An L-bit word with bit_ready held high takes exactly L cycles in SEND.
- sel arithmetic: 5-bit, wraps modulo 32. Wrap is never reached for legal L, because the word ends before wrap.
- abort (priority below reset, above everything else):
  - Next state IDLE, remaining 0, sel 0. held_word is kept.
  - load_ready is forced 0 in the abort cycle, so a simultaneous load_valid is not accepted.
  - A bit accepted in the abort cycle counts as consumed, but no further bits follow.
- Reset mid-word: the word is discarded and the reset values apply next cycle.
- load_valid in SEND while not on an accepted last beat: ignored, load_ready=0. The producer must hold it.

Decomposition:
- Shared package cpu_io_pkg:
  - state encoding (IDLE=1'b0, SEND=1'b1)
  - WORD_W=32, SEL_W=5, LEN_W=6
  - function eff_len(len) returning 32 for 0 or >32.
- One sub-module: reuse one_bit_mux_32 for bit selection; no new sub-module.
- Counters and FSM live in serial_word_sender.

Test Plan:
- Reset, then load 32'hA5A5_0001 with len 32, MSB_FIRST=0, bit_ready=1 -> first bit 1 appears one cycle after load. Bits 0..31 arrive over 32 cycles. bit_last only on cycle 32. busy then drops and load_ready=1.
- MSB_FIRST=1, load 32'h0000_000B with len 4 -> bits 1,0,1,1 with sel_out sequence 3,2,1,0. bit_last on sel_out 0.
- len 0 and len 40 -> each sends exactly 32 bits. len 1 with data 1 -> single beat, bit_out 1 and bit_last 1.
- bit_ready toggles 1,0,0,1 mid-word -> bit_out and sel_out hold during stalls. No bit is dropped or duplicated; the total beat count equals len.
- Back-to-back: second load_valid presented during the last beat of word 1 (len 3) -> load accepted that cycle and word 2's bit 0 appears the next cycle, with no bubble.
- abort asserted at beat 5 of a 16-bit word, together with load_valid=1 -> next cycle IDLE, bit_valid 0, load not taken. A separate test asserts reset mid-word -> all outputs return to their reset values next cycle.
